// File: rtl/acp_read_mover.sv
// acp_read_mover: turns 72-bit h2s read commands into 4KB-safe ACP INCR bursts,
// streams the returned beats out unchanged and reports one status byte per command.
module acp_read_mover #(
  parameter int          C_M_AXI_ADDR_WIDTH = 32,
  parameter int          C_M_AXI_DATA_WIDTH = 64,
  parameter logic [2:0]  C_PROT             = 3'b010,
  parameter int          C_MAX_BEATS        = 16,
  parameter logic [3:0]  C_CACHE            = 4'b1111
) (
  input  logic                          clk,
  input  logic                          aresetn,
  input  logic [71:0]                   S_AXIS_CMD_TDATA,
  input  logic                          S_AXIS_CMD_TVALID,
  output logic                          S_AXIS_CMD_TREADY,
  output logic [7:0]                    M_AXIS_STS_TDATA,
  output logic                          M_AXIS_STS_TVALID,
  input  logic                          M_AXIS_STS_TREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic [7:0]                    M_AXI_ARLEN,
  output logic [2:0]                    M_AXI_ARSIZE,
  output logic [1:0]                    M_AXI_ARBURST,
  output logic [3:0]                    M_AXI_ARCACHE,
  output logic [2:0]                    M_AXI_ARPROT,
  output logic                          M_AXI_ARVALID,
  input  logic                          M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
  input  logic [1:0]                    M_AXI_RRESP,
  input  logic                          M_AXI_RLAST,
  input  logic                          M_AXI_RVALID,
  output logic                          M_AXI_RREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic                          M_AXIS_TLAST,
  output logic                          M_AXIS_TVALID,
  input  logic                          M_AXIS_TREADY,
  output logic [2:0]                    dbg_state_o
);

  localparam int          AW   = C_M_AXI_ADDR_WIDTH;
  localparam logic [12:0] MAXB = 13'(C_MAX_BEATS);

  // Every channel transfers on a cycle where VALID and READY are both high at
  // the rising edge; a VALID, once raised, holds its payload until that edge.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHECK  = 3'd1,
    ADDR   = 3'd2,
    DATA   = 3'd3,
    STATUS = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [22:0] btt_q, btt_d;
  logic [19:0] beats_q, beats_d;
  logic        eof_q, eof_d;
  logic [3:0]  tag_q, tag_d;
  logic        slverr_q, slverr_d;
  logic        decerr_q, decerr_d;
  logic        interr_q, interr_d;

  logic        cmd_ready;
  logic        ar_valid;
  logic        data_phase;
  logic        sts_valid;
  logic [12:0] page_beats;
  logic [12:0] len_c;

  logic unused_cmd_bits;
  assign unused_cmd_bits = ^{S_AXIS_CMD_TDATA[71:68], S_AXIS_CMD_TDATA[31],
                             S_AXIS_CMD_TDATA[29:23]};

  // Beats left before the next 4KB page; the address is always 8-byte aligned here.
  assign page_beats = (13'd4096 - {1'b0, addr_q[11:0]}) >> 3;

  always_comb begin
    len_c = MAXB;
    if (beats_q < 20'(len_c)) len_c = beats_q[12:0];
    if (page_beats < len_c)   len_c = page_beats;
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    btt_d      = btt_q;
    beats_d    = beats_q;
    eof_d      = eof_q;
    tag_d      = tag_q;
    slverr_d   = slverr_q;
    decerr_d   = decerr_q;
    interr_d   = interr_q;
    cmd_ready  = 1'b0;
    ar_valid   = 1'b0;
    data_phase = 1'b0;
    sts_valid  = 1'b0;
    unique case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (S_AXIS_CMD_TVALID) begin
          btt_d   = S_AXIS_CMD_TDATA[22:0];
          eof_d   = S_AXIS_CMD_TDATA[30];
          addr_d  = S_AXIS_CMD_TDATA[32 +: AW];
          tag_d   = S_AXIS_CMD_TDATA[67:64];
          state_d = CHECK;
        end
      end
      CHECK: begin
        if ((btt_q == 23'd0) || (addr_q[2:0] != 3'd0) || (btt_q[2:0] != 3'd0)) begin
          interr_d = 1'b1;
          state_d  = STATUS;
        end else begin
          beats_d = btt_q[22:3];
          state_d = ADDR;
        end
      end
      ADDR: begin
        ar_valid = 1'b1;
        if (M_AXI_ARREADY) begin
          addr_d  = addr_q + (AW'(len_c) << 3);
          beats_d = beats_q - 20'(len_c);
          state_d = DATA;
        end
      end
      DATA: begin
        data_phase = 1'b1;
        if (M_AXI_RVALID && M_AXIS_TREADY) begin
          if (M_AXI_RRESP == 2'b10) slverr_d = 1'b1;
          if (M_AXI_RRESP == 2'b11) decerr_d = 1'b1;
          if (M_AXI_RLAST) state_d = (beats_q != 20'd0) ? ADDR : STATUS;
        end
      end
      STATUS: begin
        sts_valid = 1'b1;
        if (M_AXIS_STS_TREADY) begin
          slverr_d = 1'b0;
          decerr_d = 1'b0;
          interr_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      btt_q    <= '0;
      beats_q  <= '0;
      eof_q    <= 1'b0;
      tag_q    <= '0;
      slverr_q <= 1'b0;
      decerr_q <= 1'b0;
      interr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      btt_q    <= btt_d;
      beats_q  <= beats_d;
      eof_q    <= eof_d;
      tag_q    <= tag_d;
      slverr_q <= slverr_d;
      decerr_q <= decerr_d;
      interr_q <= interr_d;
    end
  end

  assign S_AXIS_CMD_TREADY = cmd_ready & aresetn;

  assign M_AXI_ARVALID = ar_valid;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARLEN   = ar_valid ? 8'(len_c - 13'd1) : 8'd0;
  assign M_AXI_ARSIZE  = 3'b011;
  assign M_AXI_ARBURST = 2'b01;
  assign M_AXI_ARCACHE = C_CACHE;
  assign M_AXI_ARPROT  = C_PROT;

  // Zero-latency pass-through: stream backpressure is the R channel's ready.
  assign M_AXIS_TDATA  = M_AXI_RDATA;
  assign M_AXIS_TVALID = data_phase & M_AXI_RVALID;
  assign M_AXI_RREADY  = data_phase & M_AXIS_TREADY;
  assign M_AXIS_TLAST  = data_phase & M_AXI_RLAST & eof_q & (beats_q == 20'd0);

  assign M_AXIS_STS_TVALID = sts_valid;
  assign M_AXIS_STS_TDATA  = sts_valid ?
      {~(slverr_q | decerr_q | interr_q), slverr_q, decerr_q, interr_q, tag_q} : 8'd0;

  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_acp_read_mover.sv
// Directed bench for acp_read_mover: AR/R slave with a memory model, stream sink,
// vector table of commands plus hand-written timing and reset sequences.
module tb_acp_read_mover;

  logic        clk = 1'b0;
  logic        aresetn;
  logic [71:0] S_AXIS_CMD_TDATA;
  logic        S_AXIS_CMD_TVALID;
  logic        S_AXIS_CMD_TREADY;
  logic [7:0]  M_AXIS_STS_TDATA;
  logic        M_AXIS_STS_TVALID;
  logic        M_AXIS_STS_TREADY;
  logic [31:0] M_AXI_ARADDR;
  logic [7:0]  M_AXI_ARLEN;
  logic [2:0]  M_AXI_ARSIZE;
  logic [1:0]  M_AXI_ARBURST;
  logic [3:0]  M_AXI_ARCACHE;
  logic [2:0]  M_AXI_ARPROT;
  logic        M_AXI_ARVALID;
  logic        M_AXI_ARREADY;
  logic [63:0] M_AXI_RDATA;
  logic [1:0]  M_AXI_RRESP;
  logic        M_AXI_RLAST;
  logic        M_AXI_RVALID;
  logic        M_AXI_RREADY;
  logic [63:0] M_AXIS_TDATA;
  logic        M_AXIS_TLAST;
  logic        M_AXIS_TVALID;
  logic        M_AXIS_TREADY;
  logic [2:0]  dbg_state_o;

  acp_read_mover dut (
    .clk               (clk),
    .aresetn           (aresetn),
    .S_AXIS_CMD_TDATA  (S_AXIS_CMD_TDATA),
    .S_AXIS_CMD_TVALID (S_AXIS_CMD_TVALID),
    .S_AXIS_CMD_TREADY (S_AXIS_CMD_TREADY),
    .M_AXIS_STS_TDATA  (M_AXIS_STS_TDATA),
    .M_AXIS_STS_TVALID (M_AXIS_STS_TVALID),
    .M_AXIS_STS_TREADY (M_AXIS_STS_TREADY),
    .M_AXI_ARADDR      (M_AXI_ARADDR),
    .M_AXI_ARLEN       (M_AXI_ARLEN),
    .M_AXI_ARSIZE      (M_AXI_ARSIZE),
    .M_AXI_ARBURST     (M_AXI_ARBURST),
    .M_AXI_ARCACHE     (M_AXI_ARCACHE),
    .M_AXI_ARPROT      (M_AXI_ARPROT),
    .M_AXI_ARVALID     (M_AXI_ARVALID),
    .M_AXI_ARREADY     (M_AXI_ARREADY),
    .M_AXI_RDATA       (M_AXI_RDATA),
    .M_AXI_RRESP       (M_AXI_RRESP),
    .M_AXI_RLAST       (M_AXI_RLAST),
    .M_AXI_RVALID      (M_AXI_RVALID),
    .M_AXI_RREADY      (M_AXI_RREADY),
    .M_AXIS_TDATA      (M_AXIS_TDATA),
    .M_AXIS_TLAST      (M_AXIS_TLAST),
    .M_AXIS_TVALID     (M_AXIS_TVALID),
    .M_AXIS_TREADY     (M_AXIS_TREADY),
    .dbg_state_o       (dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached, got no summary, required finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] mem_word(input logic [31:0] a);
    return {a ^ 32'h5A5A_C3C3, ~a};
  endfunction

  // ---------------- controls owned by the main process ----------------
  bit          stall_en = 1'b0;
  int          err_abs = -1;
  logic [1:0]  err_resp = 2'b00;
  int          flush_req = 0;

  // ---------------- logs owned by the bus process ----------------
  logic [64:0] got_beat [0:4095];
  int          got_cyc  [0:4095];
  int          beat_total = 0;
  logic [31:0] ar_log_addr [0:255];
  logic [7:0]  ar_log_len  [0:255];
  int          ar_log_cyc  [0:255];
  int          ar_total = 0;
  logic [7:0]  sts_hs_data;
  int          sts_hs_cyc = 0;
  int          sts_total = 0;
  int          ar_unstable = 0;
  int          flush_ack = 0;

  // AR/R slave with memory model, stream sink and status sink.
  initial begin : bus_model
    bit          ar_hs, r_hs, t_hs, s_hs, ar_wait;
    logic [31:0] hold_addr, burst_addr;
    logic [7:0]  hold_len;
    int          burst_left, burst_idx;
    ar_wait = 1'b0; hold_addr = '0; hold_len = '0; burst_addr = '0;
    burst_left = 0; burst_idx = 0;
    M_AXI_ARREADY = 1'b0; M_AXI_RVALID = 1'b0; M_AXI_RLAST = 1'b0;
    M_AXI_RDATA = '0; M_AXI_RRESP = 2'b00; M_AXIS_TREADY = 1'b0; M_AXIS_STS_TREADY = 1'b0;
    forever begin
      @(negedge clk);
      ar_hs = M_AXI_ARVALID && M_AXI_ARREADY;
      r_hs  = M_AXI_RVALID && M_AXI_RREADY;
      t_hs  = M_AXIS_TVALID && M_AXIS_TREADY;
      s_hs  = M_AXIS_STS_TVALID && M_AXIS_STS_TREADY;
      if (ar_wait && M_AXI_ARVALID &&
          (M_AXI_ARADDR != hold_addr || M_AXI_ARLEN != hold_len)) ar_unstable++;
      ar_wait   = M_AXI_ARVALID && !M_AXI_ARREADY;
      hold_addr = M_AXI_ARADDR;
      hold_len  = M_AXI_ARLEN;
      if (ar_hs) begin
        ar_log_addr[ar_total] = M_AXI_ARADDR;
        ar_log_len[ar_total]  = M_AXI_ARLEN;
        ar_log_cyc[ar_total]  = cyc;
        ar_total++;
        burst_addr = M_AXI_ARADDR;
        burst_left = int'(M_AXI_ARLEN) + 1;
        burst_idx  = 0;
      end
      if (t_hs) begin
        got_beat[beat_total] = {M_AXIS_TLAST, M_AXIS_TDATA};
        got_cyc[beat_total]  = cyc;
        beat_total++;
      end
      if (s_hs) begin
        sts_hs_data = M_AXIS_STS_TDATA;
        sts_hs_cyc  = cyc;
        sts_total++;
      end
      @(posedge clk); #1;
      if (r_hs) begin
        burst_left--;
        burst_idx++;
      end
      if (flush_req != flush_ack) begin
        flush_ack  = flush_req;
        burst_left = 0;
        ar_wait    = 1'b0;
        M_AXI_RVALID = 1'b0;
      end
      if (burst_left > 0) begin
        if (!M_AXI_RVALID || r_hs) begin
          M_AXI_RVALID = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
          M_AXI_RDATA  = mem_word(burst_addr + 32'(burst_idx * 8));
          M_AXI_RLAST  = (burst_left == 1);
          M_AXI_RRESP  = (beat_total == err_abs) ? err_resp : 2'b00;
        end
      end else begin
        M_AXI_RVALID = 1'b0;
        M_AXI_RLAST  = 1'b0;
        M_AXI_RRESP  = 2'b00;
      end
      M_AXI_ARREADY     = stall_en ? ($urandom_range(0, 2) == 0) : 1'b1;
      M_AXIS_TREADY     = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
      M_AXIS_STS_TREADY = stall_en ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  // ---------------- scoreboard counters ----------------
  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_int(input string name, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, got, exp);
    end
  endtask

  task automatic check_hex(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_cmd(input logic [31:0] a, input logic [22:0] btt, input bit eof,
                          input logic [3:0] tag, output int hs_cyc);
    @(posedge clk); #1;
    S_AXIS_CMD_TDATA  = {4'hA, tag, a, 1'b1, eof, 7'h55, btt};
    S_AXIS_CMD_TVALID = 1'b1;
    hs_cyc = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (S_AXIS_CMD_TREADY) begin
        hs_cyc = cyc;
        break;
      end
    end
    @(posedge clk); #1;
    S_AXIS_CMD_TVALID = 1'b0;
    check_int("cmd_accepted", int'(hs_cyc >= 0), 1);
  endtask

  task automatic wait_status(input int snap, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (sts_total != snap) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] addr;
    logic [22:0] btt;
    bit          eof;
    logic [3:0]  tag;
    int          err_idx;
    logic [1:0]  err_resp;
    bit          stall;
    bit          lat;
    logic [7:0]  exp_sts;
    int          exp_ars;
    int          exp_beats;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];
  int   last_a0, last_b0;

  task automatic run_vec(input int i);
    vec_t        v;
    int          hs, s0, nb, mism, first_bad;
    bit          ok;
    logic [64:0] exp;
    v = vecs[i];
    last_a0 = ar_total;
    last_b0 = beat_total;
    s0 = sts_total;
    err_abs  = (v.err_idx < 0) ? -1 : beat_total + v.err_idx;
    err_resp = v.err_resp;
    stall_en = v.stall;
    send_cmd(v.addr, v.btt, v.eof, v.tag, hs);
    wait_status(s0, 20000, ok);
    check_int($sformatf("sts_seen_v%0d", i), int'(ok), 1);
    if (ok) check_hex($sformatf("sts_v%0d", i), 64'(sts_hs_data), 64'(v.exp_sts));
    nb = beat_total - last_b0;
    check_int($sformatf("beats_v%0d", i), nb, v.exp_beats);
    check_int($sformatf("ars_v%0d", i), ar_total - last_a0, v.exp_ars);
    mism = 0;
    first_bad = -1;
    for (int j = 0; j < v.exp_beats && j < nb; j++) begin
      exp = {(v.eof && (j == v.exp_beats - 1)), mem_word(v.addr + 32'(j * 8))};
      if (got_beat[last_b0 + j] !== exp) begin
        mism++;
        if (first_bad < 0) first_bad = j;
      end
    end
    check_int($sformatf("data_v%0d_bad_beats(first=%0d)", i, first_bad), mism, 0);
    if (v.lat && hs >= 0) begin
      if (v.exp_ars > 0) begin
        if (ar_total > last_a0) check_int($sformatf("ar_latency_v%0d", i), ar_log_cyc[last_a0] - hs, 2);
      end else if (ok) begin
        check_int($sformatf("sts_latency_v%0d", i), sts_hs_cyc - hs, 2);
      end
    end
    stall_en = 1'b0;
    err_abs  = -1;
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int hs, b, viol;
    bit ok;
    //          addr          btt      eof   tag  err rsp    stl   lat   sts    ars beats
    vecs[0] = '{32'h1000_0000, 23'd64,   1'b1, 4'h5, -1, 2'b00, 1'b0, 1'b1, 8'h85, 1, 8};
    vecs[1] = '{32'h1000_0FF0, 23'd256,  1'b1, 4'h3, -1, 2'b00, 1'b0, 1'b1, 8'h83, 3, 32};
    vecs[2] = '{32'h2000_0000, 23'd0,    1'b1, 4'h7, -1, 2'b00, 1'b0, 1'b1, 8'h17, 0, 0};
    vecs[3] = '{32'h2000_0004, 23'd64,   1'b1, 4'h9, -1, 2'b00, 1'b0, 1'b1, 8'h19, 0, 0};
    vecs[4] = '{32'h2000_0000, 23'd12,   1'b1, 4'hA, -1, 2'b00, 1'b0, 1'b1, 8'h1A, 0, 0};
    vecs[5] = '{32'h3000_0100, 23'd64,   1'b1, 4'h2,  2, 2'b10, 1'b0, 1'b0, 8'h42, 1, 8};
    vecs[6] = '{32'h3000_0200, 23'd16,   1'b0, 4'h6,  0, 2'b11, 1'b0, 1'b0, 8'h26, 1, 2};
    vecs[7] = '{32'h4000_0FC8, 23'd1024, 1'b0, 4'hC, -1, 2'b00, 1'b1, 1'b0, 8'h8C, 9, 128};
    vecs[8] = '{32'hFFFF_FFC0, 23'd128,  1'b1, 4'hF, -1, 2'b00, 1'b0, 1'b0, 8'h8F, 2, 16};
    vecs[9] = '{32'h0000_0008, 23'd8,    1'b1, 4'h1, -1, 2'b00, 1'b0, 1'b1, 8'h81, 1, 1};

    aresetn = 1'b0;
    S_AXIS_CMD_TVALID = 1'b0;
    S_AXIS_CMD_TDATA  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_int("cmd_tready_in_reset", int'(S_AXIS_CMD_TREADY), 0);
    @(posedge clk); #1;
    aresetn = 1'b1;
    @(negedge clk);
    check_int("rst_cmd_tready", int'(S_AXIS_CMD_TREADY), 1);
    check_hex("rst_valids_rready_tlast",
              64'({M_AXI_ARVALID, M_AXIS_TVALID, M_AXIS_STS_TVALID, M_AXI_RREADY, M_AXIS_TLAST}), 64'd0);
    check_hex("rst_araddr_arlen", 64'({M_AXI_ARADDR, M_AXI_ARLEN}), 64'd0);
    check_hex("rst_sts_tdata", 64'(M_AXIS_STS_TDATA), 64'd0);
    check_hex("const_ar_fields", 64'({M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARCACHE, M_AXI_ARPROT}),
              64'({3'b011, 2'b01, 4'b1111, 3'b010}));
    check_int("rst_state_idle", int'(dbg_state_o), 0);

    for (int i = 0; i < NV; i++) begin
      run_vec(i);
      if (i == 0 && ar_total > last_a0) begin
        check_hex("v0_ar0", 64'({ar_log_addr[last_a0], ar_log_len[last_a0]}), 64'({32'h1000_0000, 8'd7}));
      end
      if (i == 1 && ar_total >= last_a0 + 3) begin
        check_hex("v1_ar0", 64'({ar_log_addr[last_a0],     ar_log_len[last_a0]}),     64'({32'h1000_0FF0, 8'd1}));
        check_hex("v1_ar1", 64'({ar_log_addr[last_a0 + 1], ar_log_len[last_a0 + 1]}), 64'({32'h1000_1000, 8'd15}));
        check_hex("v1_ar2", 64'({ar_log_addr[last_a0 + 2], ar_log_len[last_a0 + 2]}), 64'({32'h1000_1080, 8'd13}));
        if (beat_total >= last_b0 + 2)
          check_int("v1_rlast_to_ar_bubble", ar_log_cyc[last_a0 + 1] - got_cyc[last_b0 + 1], 1);
      end
      if (i == 8 && ar_total >= last_a0 + 2) begin
        check_hex("v8_wrap_ar1", 64'({ar_log_addr[last_a0 + 1], ar_log_len[last_a0 + 1]}), 64'({32'h0000_0000, 8'd7}));
      end
    end

    // Reset pulse in the middle of a long burst, then a normal command.
    stall_en = 1'b0;
    err_abs  = -1;
    b = beat_total;
    send_cmd(32'h5000_0000, 23'd1024, 1'b0, 4'h4, hs);
    ok = 1'b0;
    for (int k = 0; k < 500; k++) begin
      @(posedge clk);
      if (beat_total >= b + 3) begin
        ok = 1'b1;
        break;
      end
    end
    check_int("mid_reached_beats", int'(ok), 1);
    @(negedge clk);
    check_int("mid_state_data", int'(dbg_state_o), 3);
    aresetn = 1'b0;
    flush_req = flush_req + 1;
    @(posedge clk); #1;
    aresetn = 1'b1;
    @(negedge clk);
    check_int("after_rst_state_idle", int'(dbg_state_o), 0);
    check_hex("after_rst_valids", 64'({M_AXI_ARVALID, M_AXIS_TVALID, M_AXIS_STS_TVALID, M_AXI_RREADY}), 64'd0);
    check_int("after_rst_cmd_tready", int'(S_AXIS_CMD_TREADY), 1);
    run_vec(0);

    viol = 0;
    for (int k = 0; k < ar_total; k++) begin
      if (ar_log_len[k] > 8'd15) viol++;
      if (int'(ar_log_addr[k][11:0]) + (int'(ar_log_len[k]) + 1) * 8 > 4096) viol++;
    end
    check_int("ar_4k_and_len_rule_violations", viol, 0);
    check_int("ar_payload_unstable_while_waiting", ar_unstable, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/acp_read_mover.md
# acp_read_mover

Host-to-accelerator read engine that executes the 72-bit commands produced by the h2s `axi4_stream_master` instance. For each accepted command it issues AXI3-compatible INCR read bursts on the ACP master read channel, forwards the returned beats as the 64-bit h2s AXI stream into the custom hardware, and returns one 8-bit status word per command on the h2s status stream.

## Interface
Parameters:
- C_M_AXI_ADDR_WIDTH, 32, ACP address width
- C_M_AXI_DATA_WIDTH, 64, ACP and stream data width; only 64 is supported
- C_PROT, 3'b010, constant driven on M_AXI_ARPROT
- C_MAX_BEATS, 16, maximum beats per burst; ACP limit
- C_CACHE, 4'b1111, constant driven on M_AXI_ARCACHE

Ports:
- clk  in  1  single clock for all logic
- aresetn  in  1  reset; synchronous, active-low
- S_AXIS_CMD_TDATA  in  72  command: [22:0] BTT (bytes to transfer), [30] EOF, [63:32] start address, [67:64] tag; other bits ignored
- S_AXIS_CMD_TVALID / S_AXIS_CMD_TREADY  in/out  1  command handshake
- M_AXIS_STS_TDATA  out  8  status: [7] OKAY, [6] SLVERR, [5] DECERR, [4] INTERR, [3:0] tag
- M_AXIS_STS_TVALID / M_AXIS_STS_TREADY  out/in  1  status handshake
- M_AXI_ARADDR  out  32  burst address
- M_AXI_ARLEN  out  8  beats−1, range 0..15
- M_AXI_ARSIZE  out  3  constant 3'b011
- M_AXI_ARBURST  out  2  constant 2'b01 (INCR)
- M_AXI_ARCACHE  out  4  C_CACHE
- M_AXI_ARPROT  out  3  C_PROT
- M_AXI_ARVALID / M_AXI_ARREADY  out/in  1  read address handshake
- M_AXI_RDATA  in  64  read data
- M_AXI_RRESP  in  2  read response
- M_AXI_RLAST  in  1  last beat of burst
- M_AXI_RVALID / M_AXI_RREADY  in/out  1  read data handshake
- M_AXIS_TDATA  out  64  h2s stream data
- M_AXIS_TLAST  out  1  end of packet
- M_AXIS_TVALID / M_AXIS_TREADY  out/in  1  h2s stream handshake

## Operation
- FSM states: IDLE, CHECK, ADDR, DATA, STATUS.
- IDLE: CMD_TREADY=1. On the command handshake, latch address, BTT, EOF, and tag; go to CHECK.
- CHECK: if BTT=0, address[2:0]≠0, or BTT[2:0]≠0, set INTERR and go to STATUS with no bus traffic. Otherwise set beats_left=BTT>>3 and go to ADDR.
- ADDR: len = min(C_MAX_BEATS, beats_left, (4096−addr[11:0])>>3). Bursts never cross a 4 KB boundary. ARLEN=len−1. Hold ARVALID until ARREADY. On the handshake: addr += len*8, beats_left −= len, go to DATA.
- DATA: stream pass-through.
  - TDATA=RDATA, TVALID=RVALID, RREADY=TREADY.
  - TLAST = RLAST & EOF & (beats_left==0).
  - Every beat's RRESP is ORed into sticky flags: 2'b10 sets SLVERR, 2'b11 sets DECERR. Erroring beats are still forwarded.
  - On the RLAST handshake: beats_left≠0 → ADDR; else → STATUS.
- STATUS: STS_TDATA = {~(SLVERR|DECERR|INTERR), SLVERR, DECERR, INTERR, tag}. Hold STS_TVALID until STS_TREADY, then clear the flags and return to IDLE.
- Only one burst is outstanding at a time. No read-ID reordering is handled.
- Width rules: BTT is 23 bits, so the maximum is 1,048,575 beats. Address arithmetic is 32-bit and wraps modulo 2^32 without error.
- Reset mid-operation: the FSM returns to IDLE, flags and counters clear, and any in-flight burst is abandoned. The ACP interconnect must be reset alongside this block.

## Timing
- Reset values:
  - CMD_TREADY=0 during reset, 1 in the first cycle after reset.
  - All VALIDs=0, RREADY=0, TLAST=0.
  - ARADDR/ARLEN/STS_TDATA=0.
  - ARSIZE/ARBURST/ARCACHE/ARPROT carry their constants.
- Cycle 0 command handshake → cycle 1 CHECK → cycle 2 ARVALID=1 at the earliest.
- Error command: STS_TVALID at cycle 2.
- Data path is combinational from R to stream; zero added latency. Backpressure on TREADY propagates to RREADY in the same cycle.
- RLAST handshake → next ARVALID the following cycle (1 bubble), or STS_TVALID the following cycle.
- A new command is accepted no earlier than the cycle after the status handshake.
- ARADDR/ARLEN stay stable while ARVALID=1 and ARREADY=0.

## Test plan
- Aligned command at addr 0x1000_0000, BTT=64, EOF=1, tag=5 → one AR with ARLEN=7; 8 beats out, TLAST only on beat 8; status 0x85.
- Command at addr 0x1000_0FF0, BTT=256 → ARs at 0x..0FF0 with LEN=1, then 0x..1000 LEN=15, then 0x..1080 LEN=13; 32 beats total.
- BTT=0 or address 0x...0004 → no ARVALID; status 0x1<tag> (INTERR set) two cycles after the command handshake.
- SLVERR on beat 3 of 8 → all 8 beats forwarded; status 0x4<tag>.
- Random TREADY/ARREADY/RVALID stalls on a BTT=1024, EOF=0 command → data matches the memory model in order, TLAST never asserted, no beat dropped or duplicated.
- aresetn low for one cycle mid-DATA → next cycle all VALIDs=0 and FSM in IDLE; a new command then completes normally.
